// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock divider controller.
package clkdiv_pkg;

    // Controller states. DRAIN holds an accepted ratio until the period ends;
    // STOP finishes the current period after the run request has dropped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Smallest divide ratio that still yields a real high and low phase.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_if.sv
// Configuration handshake between a ratio producer and the divider controller.
//
// Handshake: a ratio transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready never depends on cfg_valid. The producer
// holds cfg_div stable while cfg_valid is high and the ratio has not been
// taken. cfg_err pulses for one cycle, the cycle after a transfer whose
// ratio was rejected.
interface clkdiv_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkdiv_core.sv
// Period counter, active ratio register and duty compare. Outputs are
// registered and computed from next-cycle values, so divided_clk and tick
// line up with the counter value they describe.
module clkdiv_core #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,       // asynchronous, active-low
    input  logic [WIDTH-1:0] div,         // ratio to take when load is high
    input  logic             run,         // counter is active next cycle
    input  logic             load,        // replace the active ratio next cycle
    output logic             divided_clk,
    output logic             tick,
    output logic             wrap         // this cycle is the last of the period
);

    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             run_q;
    logic             dclk_q, dclk_d;
    logic             tick_q, tick_d;
    logic [WIDTH:0]   half_d;

    assign wrap        = run_q && (cnt_q == (div_q - ONE));
    assign divided_clk = dclk_q;
    assign tick        = tick_q;

    // Next counter, ratio and registered output values.
    always_comb begin
        div_d  = load ? div : div_q;
        cnt_d  = '0;
        if (run && run_q && !wrap) begin
            cnt_d = cnt_q + ONE;
        end
        // High phase is ceil(div/2); the extra bit keeps div+1 from overflowing.
        half_d = ({1'b0, div_d} + ONE_W) >> 1;
        dclk_d = run && ({1'b0, cnt_d} < half_d);
        tick_d = run && (cnt_d == '0);
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            div_q  <= WIDTH'(DEFAULT_DIV);
            run_q  <= 1'b0;
            dclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            run_q  <= run;
            dclk_q <= dclk_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock divider controller: run/stop FSM and ratio handshake around
// clkdiv_core. Ratio changes are deferred to a period boundary so the
// divided clock never shows a truncated phase.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic     clk,
    input  logic     reset,        // asynchronous, active-low
    input  logic     en,
    clkdiv_if.slave  cfg,
    output logic     divided_clk,
    output logic     tick,
    output logic     busy,
    output state_t   dbg_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] load_val;
    logic             err_q, err_d;
    logic             alive_q;
    logic             ready;
    logic             xfer;
    logic             legal;
    logic             load;
    logic             run_next;
    logic             wrap;

    // alive_q holds ready low until the first edge after reset release.
    assign ready    = alive_q && ((state_q == IDLE) || (state_q == RUN));
    assign xfer     = cfg.cfg_valid && ready;
    assign legal    = cfg.cfg_div >= WIDTH'(MIN_DIV);
    assign run_next = (state_d != IDLE);

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

    // Next-state, pending ratio, load strobe and reject pulse.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        load     = 1'b0;
        load_val = cfg.cfg_div;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (legal) load  = 1'b1;
                    else       err_d = 1'b1;
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                if (xfer && !legal) err_d = 1'b1;
                if (xfer && legal) begin
                    // en is re-examined at the boundary in DRAIN.
                    pend_d  = cfg.cfg_div;
                    state_d = DRAIN;
                end else if (!en) begin
                    state_d = wrap ? IDLE : STOP;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    load     = 1'b1;
                    load_val = pend_q;
                    pend_d   = '0;
                    state_d  = en ? RUN : IDLE;
                end
            end
            STOP: begin
                if (en)        state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending ratio and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            alive_q <= 1'b1;
        end
    end

    clkdiv_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .div         (load_val),
        .run         (run_next),
        .load        (load),
        .divided_clk (divided_clk),
        .tick        (tick),
        .wrap        (wrap)
    );

endmodule
